// File: rtl/conv_tile_sequencer.sv
// Ifmap tile sequencer: steps the ifmap read-address generator through OX0,OY0,FX,FY,IC1,OC1 loops,
// drains the array pipeline and hands the bank back. Optional perf counters: `define SEQ_PERF_CNT_EN.
`default_nettype none

module conv_tile_sequencer #(
    parameter int CNT_WIDTH = 8,
    parameter int PIPE_LAT  = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   config_en,
    input  logic [CNT_WIDTH*6-1:0] config_data,
    input  logic                   start,
    input  logic                   ifmap_ready,
    input  logic                   stall,
    output logic                   ifmap_adr_en,
    output logic                   acc_first,
    output logic                   acc_last,
    output logic                   ifmap_switch,
    output logic                   busy,
`ifdef SEQ_PERF_CNT_EN
    output logic [31:0]            stall_cycles,
    output logic [31:0]            run_cycles,
`endif
    output logic                   done
);

    localparam int DW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [DW-1:0]        DRAIN_LAST = DW'(PIPE_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WAIT   = 3'd1,
        S_RUN    = 3'd2,
        S_DRAIN  = 3'd3,
        S_SWITCH = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [CNT_WIDTH-1:0]  r_cfg     [6];
    logic [CNT_WIDTH-1:0]  r_cnt     [6];
    logic [CNT_WIDTH-1:0]  w_bnd     [6];
    logic [CNT_WIDTH-1:0]  w_cnt_nxt [6];
    logic [6:0]            w_carry;
    logic [5:0]            w_at_last;
    logic [DW-1:0]         r_drain;
    logic                  r_busy;
    logic                  r_done;
    logic                  w_step;
    logic                  w_start_acc;
    logic                  w_drain_done;

    assign w_step       = (r_state == S_RUN) && !stall;
    assign w_start_acc  = (r_state == S_IDLE) && start;
    assign w_drain_done = (r_drain == DRAIN_LAST);

    // Effective bounds (0 means 1), per-loop wrap detection and the ox->oc carry chain.
    // Index 0 is ox (innermost) through 5 oc (outermost).
    always_comb begin
        w_carry[0] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            w_bnd[i]       = (r_cfg[i] == CNT_ZERO) ? CNT_ONE : r_cfg[i];
            w_at_last[i]   = (r_cnt[i] == (w_bnd[i] - CNT_ONE));
            w_cnt_nxt[i]   = w_carry[i] ? (w_at_last[i] ? CNT_ZERO : (r_cnt[i] + CNT_ONE)) : r_cnt[i];
            w_carry[i + 1] = w_carry[i] & w_at_last[i];
        end
    end

    assign ifmap_adr_en = w_step;
    assign acc_first    = w_step && (r_cnt[2] == CNT_ZERO) && (r_cnt[3] == CNT_ZERO) && (r_cnt[4] == CNT_ZERO);
    assign acc_last     = w_step && w_at_last[2] && w_at_last[3] && w_at_last[4];
    assign busy         = r_busy;
    assign done         = r_done;
    assign ifmap_switch = r_done;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) w_next = S_WAIT;
                else       w_next = S_IDLE;
            end
            S_WAIT: begin
                if (ifmap_ready) w_next = S_RUN;
                else             w_next = S_WAIT;
            end
            S_RUN: begin
                if (w_step && (&w_at_last)) w_next = S_DRAIN;
                else                        w_next = S_RUN;
            end
            S_DRAIN: begin
                if (w_drain_done) w_next = S_SWITCH;
                else              w_next = S_DRAIN;
            end
            S_SWITCH: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Status outputs registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= (w_next != S_IDLE);
            r_done <= (w_next == S_SWITCH);
        end
    end

    // Loop bounds; only writable while idle so a running tile never sees them change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 6; i++) r_cfg[i] <= CNT_ZERO;
        end else if ((r_state == S_IDLE) && config_en) begin
            for (int i = 0; i < 6; i++) r_cfg[i] <= config_data[(6 - i) * CNT_WIDTH - 1 -: CNT_WIDTH];
        end else begin
            for (int i = 0; i < 6; i++) r_cfg[i] <= r_cfg[i];
        end
    end

    // Loop counters advance only on an issued step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 6; i++) r_cnt[i] <= CNT_ZERO;
        end else if (w_start_acc) begin
            for (int i = 0; i < 6; i++) r_cnt[i] <= CNT_ZERO;
        end else if (w_step) begin
            for (int i = 0; i < 6; i++) r_cnt[i] <= w_cnt_nxt[i];
        end else begin
            for (int i = 0; i < 6; i++) r_cnt[i] <= r_cnt[i];
        end
    end

    // Fixed-length drain; stall has no effect here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drain <= {DW{1'b0}};
        end else if (r_state == S_DRAIN) begin
            r_drain <= r_drain + {{(DW-1){1'b0}}, 1'b1};
        end else begin
            r_drain <= {DW{1'b0}};
        end
    end

`ifdef SEQ_PERF_CNT_EN
    logic [31:0] r_run_cycles;
    logic [31:0] r_stall_cycles;

    // Saturating RUN / stalled-RUN cycle counters, cleared when a tile is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run_cycles   <= 32'd0;
            r_stall_cycles <= 32'd0;
        end else if (w_start_acc) begin
            r_run_cycles   <= 32'd0;
            r_stall_cycles <= 32'd0;
        end else if (r_state == S_RUN) begin
            r_run_cycles   <= (r_run_cycles != 32'hFFFF_FFFF) ? (r_run_cycles + 32'd1) : r_run_cycles;
            r_stall_cycles <= (stall && (r_stall_cycles != 32'hFFFF_FFFF)) ? (r_stall_cycles + 32'd1)
                                                                            : r_stall_cycles;
        end else begin
            r_run_cycles   <= r_run_cycles;
            r_stall_cycles <= r_stall_cycles;
        end
    end

    assign run_cycles   = r_run_cycles;
    assign stall_cycles = r_stall_cycles;
`endif

endmodule

`default_nettype wire

// File: tb/tb_conv_tile_sequencer.sv
// Directed self-checking bench for conv_tile_sequencer; cycle c counts from the start cycle (c=0).
module tb_conv_tile_sequencer;

    localparam int W  = 8;
    localparam int PL = 4;

    logic           clk = 1'b0;
    logic           rst_n, config_en, start, ifmap_ready, stall;
    logic [6*W-1:0] config_data;
    logic           ifmap_adr_en, acc_first, acc_last, ifmap_switch, busy, done;
`ifdef SEQ_PERF_CNT_EN
    logic [31:0]    stall_cycles, run_cycles;
`endif

    int n_cmp = 0;
    int n_err = 0;

    int steps, firsts, lasts, first_c, last_c, done_c, n_done;
    int stall_viol, gate_viol, sw_mis, wait_busy_low;
    logic [63:0] fmask, lmask;

    conv_tile_sequencer #(.CNT_WIDTH(W), .PIPE_LAT(PL)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .config_en    (config_en),
        .config_data  (config_data),
        .start        (start),
        .ifmap_ready  (ifmap_ready),
        .stall        (stall),
        .ifmap_adr_en (ifmap_adr_en),
        .acc_first    (acc_first),
        .acc_last     (acc_last),
        .ifmap_switch (ifmap_switch),
        .busy         (busy),
`ifdef SEQ_PERF_CNT_EN
        .stall_cycles (stall_cycles),
        .run_cycles   (run_cycles),
`endif
        .done         (done)
    );

    always #5 clk = ~clk;

    function automatic logic [6*W-1:0] cfg(input int ox, input int oy, input int fx,
                                           input int fy, input int ic, input int oc);
        return {8'(ox), 8'(oy), 8'(fx), 8'(fy), 8'(ic), 8'(oc)};
    endfunction

    task automatic start_tile(input logic [6*W-1:0] d, input logic load);
        @(negedge clk);
        config_en   = load;
        config_data = d;
        start       = 1'b1;
        ifmap_ready = 1'b0;
        stall       = 1'b0;
        #1;
    endtask

    // mode 0: plain, 1: stall every 3rd RUN cycle, 2: config/start/ready-drop mid-RUN
    task automatic watch(input int mode, input int rdy_delay, input int stop_at, input int budget);
        steps = 0; firsts = 0; lasts = 0; first_c = -1; last_c = -1; done_c = -1; n_done = 0;
        stall_viol = 0; gate_viol = 0; sw_mis = 0; wait_busy_low = 0;
        fmask = 64'd0; lmask = 64'd0;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            start       = 1'b0;
            config_en   = 1'b0;
            ifmap_ready = (c > rdy_delay);
            stall       = (mode == 1) && (c >= 2) && (((c - 1) % 3) == 0);
            if (mode == 2 && c == 10) begin
                config_en   = 1'b1;
                config_data = cfg(1, 1, 1, 1, 1, 1);
                start       = 1'b1;
            end
            if (mode == 2 && c >= 10 && c <= 20) ifmap_ready = 1'b0;
            #1;
            if (c <= rdy_delay && busy !== 1'b1) wait_busy_low++;
            if (ifmap_adr_en === 1'b1) begin
                steps++;
                if (first_c < 0) first_c = c;
                last_c = c;
                if (stall) stall_viol++;
                if (acc_first) begin firsts++; fmask[steps-1] = 1'b1; end
                if (acc_last)  begin lasts++;  lmask[steps-1] = 1'b1; end
            end else if (acc_first !== 1'b0 || acc_last !== 1'b0) begin
                gate_viol++;
            end
            if (ifmap_switch !== done) sw_mis++;
            if (done === 1'b1) begin n_done++; done_c = c; end
            if (done === 1'b1 || (stop_at > 0 && steps == stop_at)) break;
        end
        stall = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; config_en = 1'b0; start = 1'b0; ifmap_ready = 1'b0; stall = 1'b0;
        config_data = '0;
        repeat (2) @(negedge clk);
        #1;
        n_cmp++; if ({ifmap_adr_en, acc_first, acc_last, ifmap_switch, busy, done} !== 6'b0) begin
            n_err++; $display("FAIL reset_outputs: got %b expected 000000",
                {ifmap_adr_en, acc_first, acc_last, ifmap_switch, busy, done}); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic;
        start_tile(cfg(2, 2, 3, 3, 1, 1), 1'b1);
        watch(0, 0, 0, 200);
        n_cmp++; if (steps !== 36)      begin n_err++; $display("FAIL basic_steps: got %0d expected 36", steps); end
        n_cmp++; if (first_c !== 2)     begin n_err++; $display("FAIL basic_first_cycle: got %0d expected 2", first_c); end
        n_cmp++; if (last_c !== 37)     begin n_err++; $display("FAIL basic_contiguous: last step at %0d expected 37", last_c); end
        n_cmp++; if (firsts !== 4)      begin n_err++; $display("FAIL basic_acc_first: got %0d expected 4", firsts); end
        n_cmp++; if (lasts !== 4)       begin n_err++; $display("FAIL basic_acc_last: got %0d expected 4", lasts); end
        n_cmp++; if (done_c !== 37 + PL + 1) begin n_err++; $display("FAIL basic_done_cycle: got %0d expected %0d", done_c, 37 + PL + 1); end
        n_cmp++; if (sw_mis !== 0)      begin n_err++; $display("FAIL basic_switch_eq_done: %0d cycles differ, expected 0", sw_mis); end
        n_cmp++; if (gate_viol !== 0)   begin n_err++; $display("FAIL basic_acc_gating: %0d ungated, expected 0", gate_viol); end
`ifdef SEQ_PERF_CNT_EN
        n_cmp++; if (run_cycles !== 32'd36) begin n_err++; $display("FAIL basic_run_cycles: got %0d expected 36", run_cycles); end
`endif
        @(negedge clk); #1;
        n_cmp++; if ({busy, done, ifmap_switch} !== 3'b000) begin
            n_err++; $display("FAIL basic_idle_after: got %b expected 000", {busy, done, ifmap_switch}); end
    endtask

    task automatic test_stall;
        start_tile(cfg(2, 2, 3, 3, 1, 1), 1'b0);
        watch(1, 0, 0, 300);
        n_cmp++; if (steps !== 36)      begin n_err++; $display("FAIL stall_steps: got %0d expected 36", steps); end
        n_cmp++; if (stall_viol !== 0)  begin n_err++; $display("FAIL stall_step_in_stall: got %0d expected 0", stall_viol); end
        n_cmp++; if (last_c !== 54)     begin n_err++; $display("FAIL stall_last_cycle: got %0d expected 54", last_c); end
        n_cmp++; if (done_c !== 54 + PL + 1) begin n_err++; $display("FAIL stall_done_cycle: got %0d expected %0d", done_c, 54 + PL + 1); end
        n_cmp++; if (gate_viol !== 0)   begin n_err++; $display("FAIL stall_acc_gating: %0d ungated, expected 0", gate_viol); end
        n_cmp++; if (firsts !== 4 || lasts !== 4) begin
            n_err++; $display("FAIL stall_acc_counts: got %0d/%0d expected 4/4", firsts, lasts); end
`ifdef SEQ_PERF_CNT_EN
        n_cmp++; if (stall_cycles !== 32'd17) begin n_err++; $display("FAIL stall_perf_stall: got %0d expected 17", stall_cycles); end
        n_cmp++; if (run_cycles !== 32'd53)   begin n_err++; $display("FAIL stall_perf_run: got %0d expected 53", run_cycles); end
`endif
    endtask

    task automatic test_ic_oc;
        start_tile(cfg(1, 1, 1, 1, 2, 3), 1'b1);
        watch(0, 0, 0, 100);
        n_cmp++; if (steps !== 6) begin n_err++; $display("FAIL icoc_steps: got %0d expected 6", steps); end
        n_cmp++; if (fmask[5:0] !== 6'b010101) begin n_err++; $display("FAIL icoc_first_mask: got %b expected 010101", fmask[5:0]); end
        n_cmp++; if (lmask[5:0] !== 6'b101010) begin n_err++; $display("FAIL icoc_last_mask: got %b expected 101010", lmask[5:0]); end
        n_cmp++; if (done_c !== 7 + PL + 1) begin n_err++; $display("FAIL icoc_done_cycle: got %0d expected %0d", done_c, 7 + PL + 1); end
    endtask

    task automatic test_zero_field;
        start_tile(cfg(0, 1, 1, 1, 1, 1), 1'b1);
        watch(0, 0, 0, 100);
        n_cmp++; if (steps !== 1) begin n_err++; $display("FAIL zero_steps: got %0d expected 1", steps); end
        n_cmp++; if (firsts !== 1 || lasts !== 1) begin
            n_err++; $display("FAIL zero_acc: got %0d/%0d expected 1/1", firsts, lasts); end
        n_cmp++; if (done_c !== 2 + PL + 1) begin n_err++; $display("FAIL zero_done_cycle: got %0d expected %0d", done_c, 2 + PL + 1); end
    endtask

    task automatic test_wait_ready;
        start_tile(cfg(2, 2, 3, 3, 1, 1), 1'b1);
        watch(0, 10, 0, 200);
        n_cmp++; if (wait_busy_low !== 0) begin n_err++; $display("FAIL wait_busy: %0d low cycles, expected 0", wait_busy_low); end
        n_cmp++; if (first_c !== 12) begin n_err++; $display("FAIL wait_first_step: got %0d expected 12", first_c); end
        n_cmp++; if (steps !== 36)   begin n_err++; $display("FAIL wait_steps: got %0d expected 36", steps); end
        n_cmp++; if (done_c !== 47 + PL + 1) begin n_err++; $display("FAIL wait_done_cycle: got %0d expected %0d", done_c, 47 + PL + 1); end
    endtask

    task automatic test_protection;
        start_tile(cfg(2, 2, 3, 3, 1, 1), 1'b1);
        watch(2, 0, 0, 200);
        n_cmp++; if (steps !== 36)  begin n_err++; $display("FAIL prot_steps: got %0d expected 36", steps); end
        n_cmp++; if (done_c !== 37 + PL + 1) begin n_err++; $display("FAIL prot_done_cycle: got %0d expected %0d", done_c, 37 + PL + 1); end
        n_cmp++; if (n_done !== 1)  begin n_err++; $display("FAIL prot_done_count: got %0d expected 1", n_done); end
        @(negedge clk); #1;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL prot_start_not_queued: busy %b expected 0", busy); end
        start_tile(cfg(1, 1, 1, 1, 1, 1), 1'b0);
        watch(0, 0, 0, 200);
        n_cmp++; if (steps !== 36)  begin n_err++; $display("FAIL prot_bounds_kept: got %0d expected 36", steps); end
    endtask

    task automatic test_reset_mid;
        int bad;
        bad = 0;
        start_tile(cfg(2, 2, 3, 3, 1, 1), 1'b1);
        watch(0, 0, 10, 200);
        n_cmp++; if (steps !== 10) begin n_err++; $display("FAIL rstmid_reach: got %0d expected 10", steps); end
        #1 rst_n = 1'b0;
        #1;
        n_cmp++; if ({ifmap_adr_en, acc_first, acc_last, ifmap_switch, busy, done} !== 6'b0) begin
            n_err++; $display("FAIL rstmid_async: got %b expected 000000",
                {ifmap_adr_en, acc_first, acc_last, ifmap_switch, busy, done}); end
        repeat (4) begin
            @(negedge clk); #1;
            if (done !== 1'b0 || ifmap_switch !== 1'b0 || busy !== 1'b0) bad++;
        end
        n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL rstmid_no_done: %0d bad cycles, expected 0", bad); end
        rst_n = 1'b1;
        start_tile(cfg(2, 2, 3, 3, 1, 1), 1'b1);
        watch(0, 0, 0, 200);
        n_cmp++; if (steps !== 36) begin n_err++; $display("FAIL rstmid_restart_steps: got %0d expected 36", steps); end
        n_cmp++; if (done_c !== 37 + PL + 1) begin n_err++; $display("FAIL rstmid_restart_done: got %0d expected %0d", done_c, 37 + PL + 1); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_stall;
        test_ic_oc;
        test_zero_field;
        test_wait_ready;
        test_protection;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
